cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit for the 8-bit accumulator CPU.
- Sequences fetch, decode, memory access and execute by driving strobes to the PC, IR, accumulator, ALU and output register.
- Handshakes with instruction/data memory via req/ack.
- Drives the CPU-level halt indication.

Parameters:
- TIMEOUT, 15, max cycles waiting for mem_ack before a bus-error halt; 0 disables the watchdog.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  4  IR[7:4], valid from DECODE onward
- zero  in  1  accumulator==0 flag
- mem_ack  in  1  memory completes current access this cycle
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- addr_sel  out  1  0=PC, 1=IR operand as memory address
- ir_load  out  1  load IR from memory data
- pc_inc  out  1  PC<=PC+1
- pc_load  out  1  PC<=IR operand
- acc_load  out  1  load accumulator
- acc_src  out  1  0=ALU result, 1=external input A
- alu_op  out  2  00 pass-mem, 01 add, 10 sub, 11 and
- out_load  out  1  Output<=acc
- halt  out  1  CPU halted
- bus_err  out  1  halted due to memory timeout
- illegal  out  1  halted on illegal opcode (see Optional Feature)
- retired  out  CNT_W  instructions completed since reset

Behaviour:
- Reset (sync, active-high): state=FETCH, wait counter=0, retired=0, halt/bus_err/illegal=0, all strobes 0.
- State and counters are registered. Strobes are combinational from state, opcode and mem_ack (Mealy on ack).
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 IN, 7 OUT, 8 JMP, 9 JZ, F HLT, A-E illegal.
- FETCH:
  - mem_rd=1, addr_sel=0.
  - On mem_ack: ir_load=1, pc_inc=1, go DECODE.
- DECODE (1 cycle, no memory access):
  - NOP -> FETCH, retired+1.
  - JZ with zero=0 -> FETCH, retired+1.
  - HLT -> HALT, retired+1.
  - LDA/ADD/SUB/AND -> MEM_RD.
  - STA -> MEM_WR.
  - IN/OUT/JMP/JZ(zero=1) -> EXEC.
- MEM_RD:
  - mem_rd=1, addr_sel=1, alu_op per opcode (LDA 00, ADD 01, SUB 10, AND 11), acc_src=0.
  - On ack: acc_load=1, go FETCH, retired+1.
- MEM_WR:
  - mem_wr=1, addr_sel=1.
  - On ack: go FETCH, retired+1.
- EXEC (1 cycle), then FETCH, retired+1:
  - IN: acc_load=1, acc_src=1.
  - OUT: out_load=1.
  - JMP/JZ: pc_load=1.
- HALT: halt=1, all strobes 0, state held until rst.
- Latency with ack in first request cycle:
  - NOP / not-taken JZ: 2 cycles.
  - IN/OUT/JMP/taken JZ: 3 cycles.
  - Memory ops: 3 cycles.
- Watchdog:
  - Counter increments each cycle in FETCH/MEM_RD/MEM_WR without ack; clears on ack or state change.
  - When TIMEOUT!=0 and counter reaches TIMEOUT with no ack: go HALT, bus_err=1, no strobes issued that cycle.
  - Ack arriving on the same cycle the counter reaches TIMEOUT is honoured (ack wins).
- mem_rd and mem_wr are never both 1. pc_inc and pc_load are never both 1.
- retired saturates at all-ones (no wrap).
- rst asserted mid-access: next cycle in FETCH with all strobes 0. Any pending memory access is abandoned.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: opcodes A-E in DECODE -> HALT, illegal=1, retired not incremented.
- Undefined: A-E treated as NOP (-> FETCH, retired+1), illegal tied 0.

Test Plan:
- Program IN; ADD [3]; OUT; HLT with A=0x42, mem[3]=0x01, ack always 1 -> strobe sequence matches Behaviour; halt=1 after 11 cycles; retired=4.
- JZ with zero=1 -> pc_load pulses once in EXEC. JZ with zero=0 -> FETCH directly after DECODE, no pc_load.
- STA with mem_ack delayed 3 cycles -> mem_wr held high 4 cycles, addr_sel=1 throughout, then FETCH.
- TIMEOUT=15, mem_ack held 0 in FETCH -> halt=1 and bus_err=1 after 15 wait cycles. Ack on the 15th cycle -> normal DECODE instead.
- Opcode 0xB: with ILLEGAL_TRAP_EN -> halt=1, illegal=1, retired unchanged. Without -> continues to FETCH, retired+1.
- rst pulsed 1 cycle during MEM_RD -> next cycle FETCH, retired=0, acc_load never asserted.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for the 8-bit accumulator CPU: fetch/decode/memory/execute
// sequencing with a memory-ack watchdog. Define ILLEGAL_TRAP_EN to halt on opcodes A-E.
module cpu_ctrl_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_load,
  output logic             acc_src,
  output logic [1:0]       alu_op,
  output logic             out_load,
  output logic             halt,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
  localparam logic [CNT_W-1:0]  RET_MAX   = {CNT_W{1'b1}};

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_IN  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e             state_r;
  state_e             state_nx_s;
  logic [WAIT_W-1:0]  wait_r;
  logic [CNT_W-1:0]   retired_r;
  logic               halt_r;
  logic               bus_err_r;
  logic               illegal_r;
  logic               retire_s;
  logic               bus_trap_s;
  logic               ill_trap_s;
  logic               timeout_s;
  logic               waiting_s;

  function automatic logic [1:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_sel = 2'b01;
      OP_SUB:  alu_sel = 2'b10;
      OP_AND:  alu_sel = 2'b11;
      default: alu_sel = 2'b00;
    endcase
  endfunction

  // Next-state and strobe decode; ack beats the watchdog on the same cycle.
  always_comb begin
    state_nx_s = state_r;
    retire_s   = 1'b0;
    bus_trap_s = 1'b0;
    ill_trap_s = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_load   = 1'b0;
    acc_src    = 1'b0;
    alu_op     = 2'b00;
    out_load   = 1'b0;
    timeout_s  = (TIMEOUT != 0) && (wait_r == WAIT_LAST) && !mem_ack;
    waiting_s  = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
    case (state_r)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_nx_s = S_DECODE;
        end else if (timeout_s) begin
          state_nx_s = S_HALT;
          bus_trap_s = 1'b1;
        end else begin
          state_nx_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP: begin
            state_nx_s = S_FETCH;
            retire_s   = 1'b1;
          end
          OP_JZ: begin
            if (zero) begin
              state_nx_s = S_EXEC;
            end else begin
              state_nx_s = S_FETCH;
              retire_s   = 1'b1;
            end
          end
          OP_HLT: begin
            state_nx_s = S_HALT;
            retire_s   = 1'b1;
          end
          OP_LDA, OP_ADD, OP_SUB, OP_AND: state_nx_s = S_MEM_RD;
          OP_STA:                         state_nx_s = S_MEM_WR;
          OP_IN, OP_OUT, OP_JMP:          state_nx_s = S_EXEC;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_nx_s = S_HALT;
            ill_trap_s = 1'b1;
`else
            state_nx_s = S_FETCH;
            retire_s   = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_RD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        alu_op   = alu_sel(opcode);
        if (mem_ack) begin
          acc_load   = 1'b1;
          state_nx_s = S_FETCH;
          retire_s   = 1'b1;
        end else if (timeout_s) begin
          state_nx_s = S_HALT;
          bus_trap_s = 1'b1;
        end else begin
          state_nx_s = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) begin
          state_nx_s = S_FETCH;
          retire_s   = 1'b1;
        end else if (timeout_s) begin
          state_nx_s = S_HALT;
          bus_trap_s = 1'b1;
        end else begin
          state_nx_s = S_MEM_WR;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_IN: begin
            acc_load = 1'b1;
            acc_src  = 1'b1;
          end
          OP_OUT:        out_load = 1'b1;
          OP_JMP, OP_JZ: pc_load  = 1'b1;
          default:       out_load = 1'b0;
        endcase
        state_nx_s = S_FETCH;
        retire_s   = 1'b1;
      end
      S_HALT:  state_nx_s = S_HALT;
      default: state_nx_s = S_FETCH;
    endcase
  end

  // State, status flags and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_FETCH;
      halt_r    <= 1'b0;
      bus_err_r <= 1'b0;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      state_r   <= state_nx_s;
      halt_r    <= (state_nx_s == S_HALT);
      bus_err_r <= bus_err_r | bus_trap_s;
      illegal_r <= illegal_r | ill_trap_s;
      if (retire_s && (retired_r != RET_MAX)) begin
        retired_r <= retired_r + 1'b1;
      end
    end
  end

  // Watchdog: counts consecutive un-acked request cycles within one state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r <= '0;
    end else if (mem_ack || (state_nx_s != state_r) || !waiting_s) begin
      wait_r <= '0;
    end else if (wait_r != WAIT_MAX) begin
      wait_r <= wait_r + 1'b1;
    end
  end

  assign halt    = halt_r;
  assign bus_err = bus_err_r;
  assign illegal = illegal_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: acts as memory and datapath, compares against
// an instruction-level model. Honours ILLEGAL_TRAP_EN when the design is built with it.
module tb_cpu_ctrl_fsm;
  localparam int TO = 15;
  localparam int CW = 4;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk, rst, zero, mem_ack;
  logic [3:0] opcode;
  logic mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load, acc_src, out_load;
  logic halt, bus_err, illegal;
  logic [1:0] alu_op;
  logic [CW-1:0] retired;

  cpu_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load), .acc_src(acc_src),
    .alu_op(alu_op), .out_load(out_load), .halt(halt), .bus_err(bus_err),
    .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int cyc; int ir; int inc; int pld; int acc; int out; int rd; int wr;
    logic ret; logic hlt;
  } exp_t;

  int n_chk = 0;
  int n_pass = 0;
  bit carry;
  logic [7:0] mem_data [16];
  logic [7:0] ext_a, acc, outr, m_acc, m_out;
  int m_ret;
  int o_cyc, o_ir, o_inc, o_pld, o_acc, o_out, o_rd, o_wr, o_err;

  function automatic logic [7:0] dp_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] m);
    case (op)
      2'b01:   dp_alu = a + m;
      2'b10:   dp_alu = a - m;
      2'b11:   dp_alu = a & m;
      default: dp_alu = m;
    endcase
  endfunction

  // Instruction-level expectations for one instruction.
  function automatic exp_t model(input logic [3:0] op, input logic zv, input int df, input int dm);
    exp_t e;
    bit rdop, sta, ex, ill;
    rdop = (op == 4'h1) || (op == 4'h3) || (op == 4'h4) || (op == 4'h5);
    sta  = (op == 4'h2);
    ex   = (op == 4'h6) || (op == 4'h7) || (op == 4'h8) || (op == 4'h9 && zv);
    ill  = TRAP && (op >= 4'hA) && (op <= 4'hE);
    e.cyc = (df + 1) + 1 + ((rdop || sta) ? dm + 1 : (ex ? 1 : 0));
    e.ir  = 1;
    e.inc = 1;
    e.pld = ((op == 4'h8) || (op == 4'h9 && zv)) ? 1 : 0;
    e.acc = (rdop || op == 4'h6) ? 1 : 0;
    e.out = (op == 4'h7) ? 1 : 0;
    e.rd  = (df + 1) + (rdop ? dm + 1 : 0);
    e.wr  = sta ? dm + 1 : 0;
    e.ret = !ill;
    e.hlt = ill || (op == 4'hF);
    return e;
  endfunction

  function automatic logic [7:0] model_acc(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] m, input logic [7:0] x);
    case (op)
      4'h1:    model_acc = m;
      4'h3:    model_acc = a + m;
      4'h4:    model_acc = a - m;
      4'h5:    model_acc = a & m;
      4'h6:    model_acc = x;
      default: model_acc = a;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; carry = 1'b1;
    acc = 8'h00; outr = 8'h00; m_acc = 8'h00; m_out = 8'h00; m_ret = 0;
  endtask

  // Play memory and datapath for one instruction; ends when the next fetch or halt shows.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] opd, input logic zv,
                           input int df, input int dm);
    int fcnt, mcnt;
    bit phase, done;
    fcnt = 0; mcnt = 0; phase = 1'b0; done = 1'b0;
    o_cyc = 0; o_ir = 0; o_inc = 0; o_pld = 0; o_acc = 0; o_out = 0; o_rd = 0; o_wr = 0; o_err = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (!carry) begin @(posedge clk); #1; end
      carry = 1'b0;
      opcode = phase ? op : 4'($urandom_range(0, 15));
      zero = zv; mem_ack = 1'b0;
      #1;
      if (halt || (phase && mem_rd && !addr_sel)) begin
        done = 1'b1; carry = 1'b1;
      end else begin
        if (mem_rd || mem_wr) mem_ack = phase ? (mcnt == dm) : (fcnt == df);
        @(negedge clk);
        o_cyc++;
        o_ir  += int'(ir_load);  o_inc += int'(pc_inc); o_pld += int'(pc_load);
        o_acc += int'(acc_load); o_out += int'(out_load);
        o_rd  += int'(mem_rd);   o_wr  += int'(mem_wr);
        if ((mem_rd || mem_wr) && (addr_sel != phase)) o_err++;
        if ((mem_rd && mem_wr) || (pc_inc && pc_load)) o_err++;
        if ((mem_rd || mem_wr) && !mem_ack) begin
          if (phase) mcnt++; else fcnt++;
        end
        if (acc_load) acc = acc_src ? ext_a : dp_alu(alu_op, acc, mem_data[opd]);
        if (out_load) outr = acc;
        if (ir_load) phase = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    mem_ack = 1'b0; #1;
    n_chk++;
    if ({mem_rd, addr_sel, mem_wr, ir_load, pc_inc, pc_load, acc_load, out_load, halt, bus_err, illegal} !== 11'b100_0000_0000)
      $display("FAIL reset_outputs: got %b expected 10000000000",
               {mem_rd, addr_sel, mem_wr, ir_load, pc_inc, pc_load, acc_load, out_load, halt, bus_err, illegal});
    else n_pass++;
    n_chk++;
    if (retired !== 4'd0) $display("FAIL reset_retired: got %0d expected 0", retired);
    else n_pass++;
  endtask

  task automatic test_program();
    int total;
    do_reset();
    ext_a = 8'h42; mem_data[3] = 8'h01; total = 0;
    run_instr(4'h6, 4'h0, 1'b0, 0, 0); total += o_cyc;
    run_instr(4'h3, 4'h3, 1'b0, 0, 0); total += o_cyc;
    run_instr(4'h7, 4'h0, 1'b0, 0, 0); total += o_cyc;
    run_instr(4'hF, 4'h0, 1'b0, 0, 0); total += o_cyc;
    n_chk++;
    if (total !== 11) $display("FAIL prog_cycles: got %0d expected 11", total); else n_pass++;
    n_chk++;
    if (halt !== 1'b1 || bus_err !== 1'b0) $display("FAIL prog_halt: got halt=%b bus_err=%b expected 1/0", halt, bus_err);
    else n_pass++;
    n_chk++;
    if (retired !== 4'd4) $display("FAIL prog_retired: got %0d expected 4", retired); else n_pass++;
    n_chk++;
    if (outr !== 8'h43) $display("FAIL prog_output: got %h expected 43", outr); else n_pass++;
    mem_ack = 1'b1; #1;
    n_chk++;
    if ({mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, out_load} !== 7'b0 || halt !== 1'b1)
      $display("FAIL halt_idle: got strobes %b halt %b expected 0000000 1",
               {mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, out_load}, halt);
    else n_pass++;
  endtask

  task automatic test_jz();
    do_reset();
    run_instr(4'h9, 4'h2, 1'b1, 0, 0);
    n_chk++;
    if (o_pld !== 1 || o_cyc !== 3) $display("FAIL jz_taken: got pc_load=%0d cycles=%0d expected 1/3", o_pld, o_cyc);
    else n_pass++;
    run_instr(4'h9, 4'h2, 1'b0, 0, 0);
    n_chk++;
    if (o_pld !== 0 || o_cyc !== 2) $display("FAIL jz_not_taken: got pc_load=%0d cycles=%0d expected 0/2", o_pld, o_cyc);
    else n_pass++;
    n_chk++;
    if (retired !== 4'd2) $display("FAIL jz_retired: got %0d expected 2", retired); else n_pass++;
  endtask

  task automatic test_sta_delay();
    do_reset();
    run_instr(4'h2, 4'h5, 1'b0, 0, 3);
    n_chk++;
    if (o_wr !== 4 || o_err !== 0 || o_cyc !== 6 || halt !== 1'b0)
      $display("FAIL sta_delay: got wr=%0d err=%0d cycles=%0d halt=%b expected 4/0/6/0", o_wr, o_err, o_cyc, halt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cnt;
    bit seen_ir;
    do_reset();
    cnt = 0; seen_ir = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!carry) begin @(posedge clk); #1; end
      carry = 1'b0; mem_ack = 1'b0; opcode = 4'($urandom_range(0, 15));
      #1;
      if (halt) break;
      if (ir_load) seen_ir = 1'b1;
      cnt++;
    end
    carry = 1'b1;
    n_chk++;
    if (cnt !== TO) $display("FAIL timeout_cycles: got %0d expected %0d", cnt, TO); else n_pass++;
    n_chk++;
    if (halt !== 1'b1 || bus_err !== 1'b1 || illegal !== 1'b0 || seen_ir)
      $display("FAIL timeout_flags: got halt=%b bus_err=%b illegal=%b ir=%b expected 1/1/0/0", halt, bus_err, illegal, seen_ir);
    else n_pass++;
    do_reset();
    run_instr(4'h0, 4'h0, 1'b0, TO - 1, 0);
    n_chk++;
    if (halt !== 1'b0 || bus_err !== 1'b0 || o_ir !== 1 || retired !== 4'd1)
      $display("FAIL ack_on_last: got halt=%b bus_err=%b ir=%0d retired=%0d expected 0/0/1/1", halt, bus_err, o_ir, retired);
    else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(4'hB, 4'h0, 1'b0, 0, 0);
    n_chk++;
    if (halt !== TRAP || illegal !== TRAP || bus_err !== 1'b0)
      $display("FAIL illegal_flags: got halt=%b illegal=%b bus_err=%b expected %b/%b/0", halt, illegal, bus_err, TRAP, TRAP);
    else n_pass++;
    n_chk++;
    if (retired !== (TRAP ? 4'd0 : 4'd1)) $display("FAIL illegal_retired: got %0d expected %0d", retired, TRAP ? 0 : 1);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    bit seen_acc, in_mem;
    do_reset();
    run_instr(4'h0, 4'h0, 1'b0, 0, 0);
    mem_ack = 1'b0; opcode = 4'($urandom_range(0, 15)); #1;
    mem_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; opcode = 4'h1; mem_ack = 1'b0;
    @(posedge clk); #2;
    seen_acc = acc_load; in_mem = mem_rd && addr_sel; rst = 1'b1;
    @(negedge clk); seen_acc |= acc_load;
    @(posedge clk); #1; rst = 1'b0; #1;
    seen_acc |= acc_load;
    carry = 1'b1;
    n_chk++;
    if (!in_mem) $display("FAIL rst_mid_entry: got mem_rd&addr_sel=%b expected 1", in_mem); else n_pass++;
    n_chk++;
    if (mem_rd !== 1'b1 || addr_sel !== 1'b0 || retired !== 4'd0 || seen_acc)
      $display("FAIL rst_mid: got mem_rd=%b addr_sel=%b retired=%0d acc_load_seen=%b expected 1/0/0/0",
               mem_rd, addr_sel, retired, seen_acc);
    else n_pass++;
    acc = 8'h00; outr = 8'h00; m_acc = 8'h00; m_out = 8'h00; m_ret = 0;
  endtask

  task automatic test_random();
    exp_t e;
    logic [3:0] op, opd;
    logic zv;
    int df, dm;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op  = TRAP ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 14));
      opd = 4'($urandom_range(0, 15));
      zv  = 1'($urandom_range(0, 1));
      df  = $urandom_range(0, 4);
      dm  = $urandom_range(0, 5);
      ext_a = 8'($urandom);
      e = model(op, zv, df, dm);
      m_acc = model_acc(op, m_acc, mem_data[opd], ext_a);
      if (op == 4'h7) m_out = m_acc;
      if (e.ret && m_ret < 15) m_ret++;
      run_instr(op, opd, zv, df, dm);
      n_chk++;
      if (o_cyc !== e.cyc || o_ir !== e.ir || o_inc !== e.inc || o_pld !== e.pld ||
          o_acc !== e.acc || o_out !== e.out || o_rd !== e.rd || o_wr !== e.wr)
        $display("FAIL rand_strobes op=%h: got cyc%0d ir%0d inc%0d pld%0d acc%0d out%0d rd%0d wr%0d expected cyc%0d ir%0d inc%0d pld%0d acc%0d out%0d rd%0d wr%0d",
                 op, o_cyc, o_ir, o_inc, o_pld, o_acc, o_out, o_rd, o_wr,
                 e.cyc, e.ir, e.inc, e.pld, e.acc, e.out, e.rd, e.wr);
      else n_pass++;
      n_chk++;
      if (acc !== m_acc || outr !== m_out)
        $display("FAIL rand_datapath op=%h: got acc=%h out=%h expected %h/%h", op, acc, outr, m_acc, m_out);
      else n_pass++;
      n_chk++;
      if (retired !== CW'(m_ret)) $display("FAIL rand_retired op=%h: got %0d expected %0d", op, retired, m_ret);
      else n_pass++;
      n_chk++;
      if (o_err !== 0 || halt !== e.hlt)
        $display("FAIL rand_protocol op=%h: got errs=%0d halt=%b expected 0/%b", op, o_err, halt, e.hlt);
      else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; opcode = 4'h0; zero = 1'b0; carry = 1'b0;
    ext_a = 8'h00; acc = 8'h00; outr = 8'h00; m_acc = 8'h00; m_out = 8'h00; m_ret = 0;
    for (int i = 0; i < 16; i++) mem_data[i] = 8'($urandom);
    test_reset();
    test_program();
    test_jz();
    test_sta_delay();
    test_timeout();
    test_illegal();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
